// File: rtl/approx_pkg.sv
// Shared definitions for the serial approximate arithmetic units:
// sequencer state encoding and the approx_k width derivation.
package approx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bits needed to encode any k in 0..width inclusive.
  function automatic int kw_of(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_add_ctrl_full_adder.sv
// One-bit full-adder cell; the datapath element driven by the serial sequencers.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_add_ctrl.sv
// LSB-first bit-serial adder with run-time lower-part-OR approximation of the low k bits,
// valid/ready on both sides.
module serial_add_ctrl
  import approx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int KW    = kw_of(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [KW-1:0]    approx_k,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, res_q;
  logic [KW-1:0]    keff_q, cnt_q, k_clamp;
  logic             carry_q, out_valid_q, busy_q, in_ready_q;
  logic             fa_s, fa_c, approx, s_bit, carry_d;

  full_adder u_fa (
    .a_i (a_sh_q[0]),
    .b_i (b_sh_q[0]),
    .c_i (carry_q),
    .s_o (fa_s),
    .c_o (fa_c)
  );

  always_comb begin
    k_clamp = (approx_k > KW'(WIDTH)) ? KW'(WIDTH) : approx_k;
    approx  = (cnt_q < keff_q);
    s_bit   = fa_s;
    carry_d = fa_c;
    if (approx) begin
      // Only the top approximated bit seeds the exact upper part with a carry.
      s_bit   = a_sh_q[0] | b_sh_q[0];
      carry_d = (cnt_q == keff_q - KW'(1)) ? (a_sh_q[0] & b_sh_q[0]) : 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      res_q       <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_sh_q     <= a;
            b_sh_q     <= b;
            keff_q     <= k_clamp;
            carry_q    <= (k_clamp == '0) ? cin : 1'b0;
            cnt_q      <= '0;
            state_q    <= ST_RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ST_RUN: begin
          a_sh_q  <= a_sh_q >> 1;
          b_sh_q  <= b_sh_q >> 1;
          res_q   <= {s_bit, res_q[WIDTH-1:1]};
          carry_q <= carry_d;
          cnt_q   <= cnt_q + KW'(1);
          if (cnt_q == KW'(WIDTH - 1)) begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum       = res_q;
  assign cout      = carry_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomised and directed checks of serial_add_ctrl against an arithmetic LOA reference model.
module tb_serial_add_ctrl;

  localparam int W  = 8;
  localparam int KW = 4;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
  logic [W-1:0]  a, b, sum;
  logic [KW-1:0] approx_k;

  int n_cmp = 0;
  int n_bad = 0;

  serial_add_ctrl #(.WIDTH(W), .KW(KW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .approx_k(approx_k),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: low keff bits are a|b, the top approximated bit pair's AND carries into
  // an exact add of the upper parts; keff==0 is a plain a+b+cin.
  function automatic logic [8:0] ref_add(input int ai, input int bi, input int ci, input int k);
    int keff, mask, low, c, high, s, co;
    keff = (k > W) ? W : k;
    if (keff == 0) begin
      s  = ai + bi + ci;
      return s[8:0];
    end
    mask = (1 << keff) - 1;
    low  = (ai | bi) & mask;
    c    = ((ai >> (keff - 1)) & (bi >> (keff - 1))) & 1;
    high = (ai >> keff) + (bi >> keff) + c;
    s    = ((high << keff) | low) & 'hFF;
    co   = (high >> (W - keff)) & 1;
    return {co[0], s[7:0]};
  endfunction

  task automatic run_op(input string tag, input logic [W-1:0] ai, input logic [W-1:0] bi,
                        input logic ci, input logic [KW-1:0] k, input int hold);
    logic [8:0]   exp;
    logic [W-1:0] s0;
    logic         c0;
    int           n;
    exp = ref_add(int'(ai), int'(bi), int'(ci), int'(k));
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".ready"}, in_ready, 1'b1);
    a = ai; b = bi; cin = ci; approx_k = k; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, ".busy"}, busy, 1'b1);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".lat"}, n, W);
    chk({tag, ".sum"}, sum, exp[7:0]);
    chk({tag, ".cout"}, cout, exp[8]);
    s0 = sum; c0 = cout;
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0];
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom); approx_k = KW'($urandom);
      @(negedge clk);
      chk({tag, ".hold"}, {out_valid, in_ready, c0, s0}, {1'b1, 1'b0, cout, sum});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".release"}, {out_valid, busy, in_ready}, 3'b001);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; approx_k = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset", {in_ready, out_valid, busy, cout, sum}, {3'b100, 1'b0, 8'h00});

    run_op("exact",    8'h35, 8'h4A, 1'b0, 4'd0, 0);
    run_op("ovf_cin",  8'hFF, 8'h00, 1'b1, 4'd0, 0);
    run_op("ovf",      8'hFF, 8'h01, 1'b0, 4'd0, 0);
    run_op("loa4",     8'h18, 8'h08, 1'b0, 4'd4, 1);
    run_op("loa4cin",  8'h0F, 8'h01, 1'b1, 4'd4, 0);
    run_op("clamp",    8'hC3, 8'h81, 1'b0, 4'd9, 0);
    run_op("full",     8'h80, 8'h80, 1'b1, 4'd8, 0);
    run_op("k1",       8'h7F, 8'h01, 1'b0, 4'd1, 0);
    run_op("bp",       8'h5A, 8'hA5, 1'b1, 4'd2, 5);

    // Reset in the middle of RUN.
    a = 8'hAA; b = 8'h55; cin = 1'b0; approx_k = '0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst", {in_ready, out_valid, busy}, 3'b100);
    repeat (10) begin
      @(negedge clk);
      chk("midrst.quiet", out_valid, 1'b0);
    end
    run_op("after_rst", 8'h01, 8'h02, 1'b0, 4'd0, 0);

    for (int t = 0; t < 40; t++)
      run_op("rand", W'($urandom), W'($urandom), 1'($urandom), KW'($urandom_range(0, 15)),
             int'($urandom_range(0, 3)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
